// File: rtl/apb_req_master_pkg.sv
// apb_req_master_pkg: shared types for the APB request master.
// FSM state encoding lives here so every user sees one definition.
package apb_req_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Counter width able to hold 0..n-1, never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/APB_BUS.sv
// APB_BUS: plain APB3 signal bundle with master/slave views.
// Width parameters must match those of the attached master.
interface APB_BUS #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pwrite;
  logic                  psel;
  logic                  penable;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport Master (
    output paddr, pwdata, pwrite, psel, penable,
    input  prdata, pready, pslverr
  );

  modport Slave (
    input  paddr, pwdata, pwrite, psel, penable,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_req_master.sv
// apb_req_master: single-outstanding APB initiator, valid/ready in and out.
// Define APB_REQ_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES.
module apb_req_master
  import apb_req_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic                  req_write_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  APB_BUS.Master                apb
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
  } rsp_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  state_e                state_q;
  rsp_t                  rsp_q;
  logic                  rsp_valid_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;

`ifdef APB_REQ_MASTER_TIMEOUT_EN
  localparam int unsigned CntW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q;
`endif

  // Transfer sequencer: all APB and response outputs are registered here.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
`ifdef APB_REQ_MASTER_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            state_q  <= SETUP;
            psel_q   <= 1'b1;
            pwrite_q <= req_write_i;
            paddr_q  <= req_addr_i;
            pwdata_q <= req_wdata_i;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
`ifdef APB_REQ_MASTER_TIMEOUT_EN
          cnt_q     <= '0;
`endif
        end
        ACCESS: begin
          if (apb.pready) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_q.rdata <= pwrite_q ? '0 : apb.prdata;
            rsp_q.err   <= apb.pslverr;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
`ifdef APB_REQ_MASTER_TIMEOUT_EN
          end else if (cnt_q == CntLast) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_q.rdata <= '0;
            rsp_q.err   <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
`endif
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_q.rdata;
  assign rsp_err_o   = rsp_q.err;

  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.paddr   = paddr_q;
  assign apb.pwdata  = pwdata_q;

endmodule
